bvh_node_stream_packer: RTL and testbench
=========================================

BVH_NODE_STREAM_PACKER -- requirements
Module: bvh_node_stream_packer

Interface
REQ-001 Parameters SHALL be, one per line:
  COORD_W, 16, quantized bbox coordinate width
  OFF_W, 14, interior child relative-offset width
  PIDX_W, 19, leaf base primitive index width
  PCNT_W, 12, leaf primitive count width
  BUS_W, 64, memory write-bus width, power of two, >= 32
  ADDR_W, 32, byte-address width
REQ-002 Derived widths SHALL be:
  UNION_W = 1 + max(2+2*OFF_W, PIDX_W+PCNT_W).
  NODE_W = 6*COORD_W + UNION_W.
  BEATS = ceil(NODE_W/BUS_W).
  NODE_BYTES = BEATS*BUS_W/8.
REQ-003 Ports SHALL be, one per line:
  clk  in  1  clock
  rst_n  in  1  reset
  start  in  1  begin new tree, loads base_addr
  base_addr  in  ADDR_W  byte address of node 0
  in_valid  in  1  node descriptor valid
  in_ready  out  1  descriptor accepted when both high
  is_leaf  in  1  1=leaf, 0=interior
  axis  in  2  split axis, 3 is illegal
  child0_off, child1_off  in  OFF_W each  interior offsets
  prim_index  in  PIDX_W  leaf fields
  prim_count  in  PCNT_W  leaf fields
  min_x..max_z  in  COORD_W each  quantized bbox
  mem_valid  out  1  write beat valid
  mem_ready  in  1  beat accepted when both high
  mem_addr  out  ADDR_W  beat byte address
  mem_data  out  BUS_W  beat data
  mem_last  out  1  final beat of node
  node_count  out  ADDR_W  nodes fully written since start
  err  out  3  sticky flags: [0] bad box, [1] empty leaf/illegal axis, [2] start while busy
REQ-004 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.

Function
REQ-005 Node image SHALL be {zero pad, max_z, max_y, max_x, min_z, min_y, min_x, union}, with union at the LSBs.
REQ-006 Union MSB SHALL carry is_leaf.
  Leaf: {1, zero pad, prim_index, prim_count}.
  Interior: {0, zero pad, axis, child0_off, child1_off}.
  No field SHALL be truncated.
REQ-007 Beat k (0..BEATS-1) SHALL carry node image bits [k*BUS_W +: BUS_W].
REQ-008 FSM states SHALL be IDLE and SEND.
  IDLE->SEND on an accepted descriptor.
  SEND->IDLE on an accepted last beat with no new descriptor accepted.
  SEND->SEND on an accepted last beat with a descriptor accepted in the same cycle.
REQ-009 in_ready SHALL equal (state==IDLE) | (mem_valid & mem_last & mem_ready), so sustained throughput is one node per BEATS cycles.
REQ-010 Accepted descriptor SHALL be registered; first beat SHALL appear on mem_* the cycle after acceptance (latency 1).
REQ-011 mem_valid SHALL be high exactly in SEND.
  mem_data, mem_addr and mem_last SHALL hold stable while mem_valid & !mem_ready.
REQ-012 mem_addr SHALL be base_reg + node_idx*NODE_BYTES + beat*(BUS_W/8), computed modulo 2^ADDR_W with wrap permitted and no flag.
REQ-013 node_idx SHALL increment on acceptance of each last beat.
  node_count SHALL equal node_idx.
  Both SHALL wrap at 2^ADDR_W.
REQ-014 start in IDLE SHALL load base_reg, clear node_idx and clear err.
  start in SEND SHALL be ignored except for setting err[2].
  start with in_valid in IDLE SHALL load first; the descriptor is accepted the same cycle, as node 0.
REQ-015 err[0] SHALL set on acceptance if any min_* > max_* (unsigned compare).
REQ-016 err[1] SHALL set on acceptance of a leaf with prim_count==0 or an interior with axis==3.
REQ-017 Erroneous nodes SHALL still be packed and written unmodified.

Reset
REQ-018 Reset SHALL force:
  state=IDLE, in_ready=1, mem_valid=0, mem_last=0.
  mem_data=0, mem_addr=0.
  base_reg=0, node_idx=0, beat=0, err=0.
REQ-019 Reset mid-node SHALL abandon the node with no further beats; the partial write is the consumer's concern.

Structure
REQ-020 Package bvh_pkg SHALL hold axis enum, node-kind constant, UNION_W/NODE_W/BEATS/NODE_BYTES functions and err bit indices.
REQ-021 Combinational image assembly SHALL live in sub-module bvh_node_image; FSM, address and error logic SHALL live in the top.

Verification
REQ-022 Defaults, start base=0x1000, one leaf (idx=5, cnt=3, box 1..2), mem_ready=1 -> two beats at 0x1000/0x1008, beat1 mem_last=1, node_count=1, err=0.
REQ-023 Three back-to-back interiors, mem_ready=1 -> in_ready high every 2nd cycle, addresses 0x1000..0x1028 contiguous, no gap cycles.
REQ-024 mem_ready toggled 1-0-0-1 pseudo-randomly -> mem_* stable during stalls, no beat lost or duplicated, image matches model.
REQ-025 Leaf cnt=0, then interior axis=3, then min_x=9/max_x=4 -> err=3'b011 sticky, all three nodes still written.
REQ-026 start asserted in SEND, then rst_n low at beat 0 of next node -> err[2]=1 before reset; after reset all outputs at REQ-018 values, no further beats.
REQ-027 BUS_W=32 build -> BEATS=4, NODE_BYTES=16, per-beat address step 4.

Source files
------------

// File: rtl/bvh_pkg.sv
// -----------------------------------------------------------------------------
// bvh_pkg
// Shared definitions for the BVH node stream packer:
//   - split-axis encoding and node-kind constants
//   - sticky error flag bit positions
//   - FSM state encoding
//   - helper functions deriving the packed node geometry from field widths
// No ports (package).
// -----------------------------------------------------------------------------
package bvh_pkg;

  typedef enum logic [1:0] {
    AXIS_X       = 2'd0,
    AXIS_Y       = 2'd1,
    AXIS_Z       = 2'd2,
    AXIS_ILLEGAL = 2'd3
  } axis_e;

  localparam logic NODE_KIND_INTERIOR = 1'b0;
  localparam logic NODE_KIND_LEAF     = 1'b1;

  // Sticky error flag positions inside err.
  localparam int ERR_BAD_BOX    = 0;  // some min_* > max_*
  localparam int ERR_BAD_NODE   = 1;  // empty leaf or interior with illegal axis
  localparam int ERR_START_BUSY = 2;  // start raised while a node was streaming
  localparam int ERR_W          = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Width of the kind-tagged union: one tag bit plus the wider of the two payloads.
  function automatic int union_w(input int off_w, input int pidx_w, input int pcnt_w);
    int interior_w;
    int leaf_w;
    interior_w = 2 + 2 * off_w;
    leaf_w     = pidx_w + pcnt_w;
    return 1 + ((interior_w > leaf_w) ? interior_w : leaf_w);
  endfunction

  function automatic int node_w(input int coord_w, input int uw);
    return 6 * coord_w + uw;
  endfunction

  function automatic int beats(input int nw, input int bus_w);
    return (nw + bus_w - 1) / bus_w;
  endfunction

  function automatic int node_bytes(input int n_beats, input int bus_w);
    return n_beats * bus_w / 8;
  endfunction

endpackage

// File: rtl/bvh_node_image.sv
// -----------------------------------------------------------------------------
// bvh_node_image
// Purely combinational assembly of one packed BVH node image.
// Layout (LSB first): union, min_x, min_y, min_z, max_x, max_y, max_z.
// The union's MSB is the node kind; the payload sits at the union LSBs:
//   leaf     : {1, pad, prim_index, prim_count}
//   interior : {0, pad, axis, child0_off, child1_off}
// Ports:
//   is_leaf_i, axis_i, child0_off_i, child1_off_i, prim_index_i, prim_count_i
//   min_*_i / max_*_i  quantized bounding box
//   image_o            NODE_W-bit node image
// -----------------------------------------------------------------------------
module bvh_node_image
  import bvh_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int OFF_W   = 14,
  parameter int PIDX_W  = 19,
  parameter int PCNT_W  = 12,
  parameter int UNION_W = union_w(OFF_W, PIDX_W, PCNT_W),
  parameter int NODE_W  = node_w(COORD_W, UNION_W)
) (
  input  logic               is_leaf_i,
  input  logic [1:0]         axis_i,
  input  logic [OFF_W-1:0]   child0_off_i,
  input  logic [OFF_W-1:0]   child1_off_i,
  input  logic [PIDX_W-1:0]  prim_index_i,
  input  logic [PCNT_W-1:0]  prim_count_i,
  input  logic [COORD_W-1:0] min_x_i,
  input  logic [COORD_W-1:0] min_y_i,
  input  logic [COORD_W-1:0] min_z_i,
  input  logic [COORD_W-1:0] max_x_i,
  input  logic [COORD_W-1:0] max_y_i,
  input  logic [COORD_W-1:0] max_z_i,
  output logic [NODE_W-1:0]  image_o
);

  logic [UNION_W-1:0] node_union;

  // NOTE: every variable assigned in always_comb gets a full default first;
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    node_union = '0;
    if (is_leaf_i == NODE_KIND_LEAF) begin
      node_union[PCNT_W-1:0]      = prim_count_i;
      node_union[PCNT_W +: PIDX_W] = prim_index_i;
    end else begin
      node_union[OFF_W-1:0]        = child1_off_i;
      node_union[OFF_W +: OFF_W]   = child0_off_i;
      node_union[2*OFF_W +: 2]     = axis_i;
    end
    // The tag bit lies above both payloads, so it never overlaps a field.
    node_union[UNION_W-1] = is_leaf_i;
  end

  assign image_o = {max_z_i, max_y_i, max_x_i, min_z_i, min_y_i, min_x_i, node_union};

endmodule

// File: rtl/bvh_node_stream_packer.sv
// -----------------------------------------------------------------------------
// bvh_node_stream_packer
// Accepts BVH node descriptors and streams each packed node image to memory
// as BEATS consecutive bus-wide write beats at contiguous byte addresses.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, base_addr           begin a new tree at base_addr (honoured in IDLE)
//   in_valid/in_ready          descriptor handshake
//   is_leaf, axis, child*_off, prim_index, prim_count, min_*/max_*  descriptor
//   mem_valid/mem_ready        write beat handshake
//   mem_addr, mem_data, mem_last  beat address, data, final-beat marker
//   node_count                 nodes completely written since start
//   err                        sticky flags (bad box, bad node, start while busy)
// -----------------------------------------------------------------------------
module bvh_node_stream_packer
  import bvh_pkg::*;
#(
  parameter int COORD_W = 16,
  parameter int OFF_W   = 14,
  parameter int PIDX_W  = 19,
  parameter int PCNT_W  = 12,
  parameter int BUS_W   = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_leaf,
  input  logic [1:0]         axis,
  input  logic [OFF_W-1:0]   child0_off,
  input  logic [OFF_W-1:0]   child1_off,
  input  logic [PIDX_W-1:0]  prim_index,
  input  logic [PCNT_W-1:0]  prim_count,
  input  logic [COORD_W-1:0] min_x,
  input  logic [COORD_W-1:0] min_y,
  input  logic [COORD_W-1:0] min_z,
  input  logic [COORD_W-1:0] max_x,
  input  logic [COORD_W-1:0] max_y,
  input  logic [COORD_W-1:0] max_z,
  output logic               mem_valid,
  input  logic               mem_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BUS_W-1:0]   mem_data,
  output logic               mem_last,
  output logic [ADDR_W-1:0]  node_count,
  output logic [ERR_W-1:0]   err
);

  localparam int UNION_W    = union_w(OFF_W, PIDX_W, PCNT_W);
  localparam int NODE_W     = node_w(COORD_W, UNION_W);
  localparam int BEATS      = beats(NODE_W, BUS_W);
  localparam int NODE_BYTES = node_bytes(BEATS, BUS_W);
  localparam int IMG_W      = BEATS * BUS_W;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] NODE_STRIDE = ADDR_W'(NODE_BYTES);
  localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(BUS_W / 8);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [IMG_W-1:0]   img_q, img_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  node_idx_q, node_idx_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic [NODE_W-1:0]  node_image;
  logic               accept;
  logic               beat_acc;
  logic               last_acc;
  logic               start_idle;
  logic               start_busy;
  logic               bad_box;
  logic               bad_node;

  // ---------------------------------------------------------------------------
  // Image assembly
  // ---------------------------------------------------------------------------
  bvh_node_image #(
    .COORD_W (COORD_W),
    .OFF_W   (OFF_W),
    .PIDX_W  (PIDX_W),
    .PCNT_W  (PCNT_W)
  ) u_image (
    .is_leaf_i    (is_leaf),
    .axis_i       (axis),
    .child0_off_i (child0_off),
    .child1_off_i (child1_off),
    .prim_index_i (prim_index),
    .prim_count_i (prim_count),
    .min_x_i      (min_x),
    .min_y_i      (min_y),
    .min_z_i      (min_z),
    .max_x_i      (max_x),
    .max_y_i      (max_y),
    .max_z_i      (max_z),
    .image_o      (node_image)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SEND;
      // A descriptor taken on the last beat keeps the stream going without a bubble.
      ST_SEND: if (last_acc && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_valid = (state_q == ST_SEND);
    mem_last  = mem_valid && (beat_q == LAST_BEAT);
    // Ready again on the cycle the last beat leaves, giving one node per BEATS cycles.
    in_ready  = (state_q == ST_IDLE) || (mem_valid && mem_last && mem_ready);
  end

  // ---------------------------------------------------------------------------
  // Handshakes and descriptor checks
  // ---------------------------------------------------------------------------
  assign accept     = in_valid & in_ready;
  assign beat_acc   = mem_valid & mem_ready;
  assign last_acc   = beat_acc & mem_last;
  assign start_idle = start & (state_q == ST_IDLE);
  assign start_busy = start & (state_q == ST_SEND);

  assign bad_box  = (min_x > max_x) | (min_y > max_y) | (min_z > max_z);
  assign bad_node = (is_leaf == NODE_KIND_LEAF) ? (prim_count == '0)
                                                : (axis == AXIS_ILLEGAL);

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    base_d     = base_q;
    node_idx_d = node_idx_q;
    err_d      = err_q;
    beat_d     = beat_q;
    img_d      = img_q;

    // A new tree restarts numbering and flags; a start during a node is only recorded.
    if (start_idle) begin
      base_d     = base_addr;
      node_idx_d = '0;
      err_d      = '0;
    end
    if (start_busy) begin
      err_d[ERR_START_BUSY] = 1'b1;
    end

    if (last_acc) begin
      node_idx_d = node_idx_q + ADDR_W'(1);
    end

    // Faulty nodes are flagged but still written exactly as described.
    if (accept) begin
      img_d = IMG_W'(node_image);
      if (bad_box)  err_d[ERR_BAD_BOX]  = 1'b1;
      if (bad_node) err_d[ERR_BAD_NODE] = 1'b1;
    end

    if (accept || last_acc) begin
      beat_d = '0;
    end else if (beat_acc) begin
      beat_d = beat_q + BEAT_W'(1);
    end
  end

  // NOTE: the image register is reset too, because mem_data is defined to read
  // zero straight out of reset rather than whatever the flops powered up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q     <= '0;
      img_q      <= '0;
      base_q     <= '0;
      node_idx_q <= '0;
      err_q      <= '0;
    end else begin
      beat_q     <= beat_d;
      img_q      <= img_d;
      base_q     <= base_d;
      node_idx_q <= node_idx_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Beat outputs: everything derives from registers, so stalls hold them stable.
  // ---------------------------------------------------------------------------
  assign mem_data   = img_q[beat_q * BUS_W +: BUS_W];
  assign mem_addr   = base_q + node_idx_q * NODE_STRIDE + ADDR_W'(beat_q) * BEAT_STRIDE;
  assign node_count = node_idx_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bvh_node_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_bvh_node_stream_packer
// Scoreboard bench for the BVH node stream packer. Two instances share the
// descriptor, start, reset and mem_ready stimulus: the default 64-bit bus build
// and a 32-bit bus build, each with its own in_valid. Expected beats are built
// from the node layout rules and queued on acceptance; per-instance monitors
// compare every presented beat (including stalled cycles) against the queue.
// -----------------------------------------------------------------------------
module tb_bvh_node_stream_packer;

  typedef struct packed {
    logic        is_leaf;
    logic [1:0]  axis;
    logic [13:0] c0;
    logic [13:0] c1;
    logic [18:0] pidx;
    logic [11:0] pcnt;
    logic [15:0] min_x, min_y, min_z, max_x, max_y, max_z;
  } desc_t;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid64, in_valid32;
  logic        in_ready64, in_ready32;
  logic        is_leaf;
  logic [1:0]  axis;
  logic [13:0] child0_off, child1_off;
  logic [18:0] prim_index;
  logic [11:0] prim_count;
  logic [15:0] min_x, min_y, min_z, max_x, max_y, max_z;
  logic        mem_ready;

  logic        mem_valid64, mem_last64;
  logic [31:0] mem_addr64, node_count64;
  logic [63:0] mem_data64;
  logic [2:0]  err64;

  logic        mem_valid32, mem_last32;
  logic [31:0] mem_addr32, node_count32;
  logic [31:0] mem_data32;
  logic [2:0]  err32;

  bvh_node_stream_packer u_dut64 (
    .clk (clk), .rst_n (rst_n), .start (start), .base_addr (base_addr),
    .in_valid (in_valid64), .in_ready (in_ready64),
    .is_leaf (is_leaf), .axis (axis), .child0_off (child0_off), .child1_off (child1_off),
    .prim_index (prim_index), .prim_count (prim_count),
    .min_x (min_x), .min_y (min_y), .min_z (min_z),
    .max_x (max_x), .max_y (max_y), .max_z (max_z),
    .mem_valid (mem_valid64), .mem_ready (mem_ready), .mem_addr (mem_addr64),
    .mem_data (mem_data64), .mem_last (mem_last64),
    .node_count (node_count64), .err (err64)
  );

  bvh_node_stream_packer #(.BUS_W(32)) u_dut32 (
    .clk (clk), .rst_n (rst_n), .start (start), .base_addr (base_addr),
    .in_valid (in_valid32), .in_ready (in_ready32),
    .is_leaf (is_leaf), .axis (axis), .child0_off (child0_off), .child1_off (child1_off),
    .prim_index (prim_index), .prim_count (prim_count),
    .min_x (min_x), .min_y (min_y), .min_z (min_z),
    .max_x (max_x), .max_y (max_y), .max_z (max_z),
    .mem_valid (mem_valid32), .mem_ready (mem_ready), .mem_addr (mem_addr32),
    .mem_data (mem_data32), .mem_last (mem_last32),
    .node_count (node_count32), .err (err32)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  longint      cycle    = 0;
  longint      acc_cycle[$];
  beat_t       exp64[$];
  beat_t       exp32[$];
  logic [31:0] m_base[2];
  logic [31:0] m_idx[2];
  logic [2:0]  m_err[2];
  bit          rand_ready = 1'b0;

  always @(posedge clk) cycle++;

  // mem_ready pattern: random 1/0 stream while enabled.
  always @(negedge clk) if (rand_ready) mem_ready = 1'($urandom_range(0, 1));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] image_of(input desc_t d);
    logic [31:0] u;
    if (d.is_leaf) u = 32'h8000_0000 | (32'(d.pidx) << 12) | 32'(d.pcnt);
    else           u = (32'(d.axis) << 28) | (32'(d.c0) << 14) | 32'(d.c1);
    return {d.max_z, d.max_y, d.max_x, d.min_z, d.min_y, d.min_x, u};
  endfunction

  function automatic void model_accept(input int sel, input bit with_start,
                                       input logic [31:0] base, input desc_t d);
    logic [127:0] img;
    int           nbeats;
    int           bits;
    beat_t        b;
    img    = image_of(d);
    nbeats = (sel == 0) ? 2 : 4;
    bits   = (sel == 0) ? 64 : 32;
    if (with_start) begin
      m_base[sel] = base;
      m_idx[sel]  = 0;
      m_err[sel]  = 0;
    end
    if (d.min_x > d.max_x || d.min_y > d.max_y || d.min_z > d.max_z) m_err[sel][0] = 1'b1;
    if (d.is_leaf ? (d.pcnt == 0) : (d.axis == 2'd3)) m_err[sel][1] = 1'b1;
    for (int k = 0; k < nbeats; k++) begin
      b.addr = 32'(m_base[sel] + m_idx[sel] * 16 + 32'(k * bits / 8));
      b.data = 64'(img >> (k * bits));
      if (sel == 1) b.data[63:32] = '0;
      b.last = (k == nbeats - 1);
      if (sel == 0) exp64.push_back(b);
      else          exp32.push_back(b);
    end
    m_idx[sel] = m_idx[sel] + 1;
  endfunction

  function automatic desc_t good_desc(input bit leaf);
    desc_t d;
    d.is_leaf = leaf;
    d.axis    = 2'($urandom_range(0, 2));
    d.c0      = 14'($urandom);
    d.c1      = 14'($urandom);
    d.pidx    = 19'($urandom);
    d.pcnt    = 12'($urandom_range(1, 4095));
    d.min_x   = 16'($urandom_range(0, 1000));
    d.min_y   = 16'($urandom_range(0, 1000));
    d.min_z   = 16'($urandom_range(0, 1000));
    d.max_x   = d.min_x + 16'($urandom_range(0, 1000));
    d.max_y   = d.min_y + 16'($urandom_range(0, 1000));
    d.max_z   = d.min_z + 16'($urandom_range(0, 1000));
    return d;
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    d.is_leaf = 1'($urandom_range(0, 1));
    d.axis    = 2'($urandom_range(0, 3));
    d.c0      = 14'($urandom);
    d.c1      = 14'($urandom);
    d.pidx    = 19'($urandom);
    d.pcnt    = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom);
    d.min_x   = 16'($urandom);
    d.min_y   = 16'($urandom);
    d.min_z   = 16'($urandom);
    d.max_x   = 16'($urandom);
    d.max_y   = 16'($urandom);
    d.max_z   = 16'($urandom);
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitors: compare every presented beat; pop when it is accepted.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    #1;
    if (rst_n && mem_valid64) begin
      if (exp64.size() == 0) begin
        check("unexpected_beat64", mem_valid64, 0);
      end else begin
        check("beat64_addr", mem_addr64, exp64[0].addr);
        check("beat64_data", mem_data64, exp64[0].data);
        check("beat64_last", mem_last64, exp64[0].last);
        if (mem_ready) void'(exp64.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst_n && mem_valid32) begin
      if (exp32.size() == 0) begin
        check("unexpected_beat32", mem_valid32, 0);
      end else begin
        check("beat32_addr", mem_addr32, exp32[0].addr);
        check("beat32_data", mem_data32, exp32[0].data);
        check("beat32_last", mem_last32, exp32[0].last);
        if (mem_ready) void'(exp32.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic issue(input int sel, input bit with_start, input logic [31:0] base,
                       input desc_t d);
    bit done;
    done       = 1'b0;
    is_leaf    = d.is_leaf;
    axis       = d.axis;
    child0_off = d.c0;
    child1_off = d.c1;
    prim_index = d.pidx;
    prim_count = d.pcnt;
    min_x = d.min_x; min_y = d.min_y; min_z = d.min_z;
    max_x = d.max_x; max_y = d.max_y; max_z = d.max_z;
    base_addr  = base;
    start      = with_start;
    if (sel == 0) in_valid64 = 1'b1;
    else          in_valid32 = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      #2;
      if ((sel == 0) ? in_ready64 : in_ready32) begin
        done = 1'b1;
        model_accept(sel, with_start, base, d);
        acc_cycle.push_back(cycle);
      end
      @(negedge clk);
    end
    in_valid64 = 1'b0;
    in_valid32 = 1'b0;
    start      = 1'b0;
    if (!done) check("issue_timeout", (sel == 0) ? in_ready64 : in_ready32, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    #3;
    while ((exp64.size() != 0 || exp32.size() != 0 || mem_valid64 || mem_valid32) && t < 2000) begin
      @(negedge clk);
      #3;
      t++;
    end
    if (t >= 2000) check("drain_timeout", 128'(exp64.size() + exp32.size()), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   in_ready64,   1);
    check({tag, "_mem_valid"},  mem_valid64,  0);
    check({tag, "_mem_last"},   mem_last64,   0);
    check({tag, "_mem_data"},   mem_data64,   0);
    check({tag, "_mem_addr"},   mem_addr64,   0);
    check({tag, "_node_count"}, node_count64, 0);
    check({tag, "_err"},        err64,        0);
  endtask

  // Watchdog: the run must always end.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    desc_t d;
    rst_n = 1'b0; start = 1'b0; base_addr = '0;
    in_valid64 = 1'b0; in_valid32 = 1'b0; mem_ready = 1'b1;
    is_leaf = 1'b0; axis = '0; child0_off = '0; child1_off = '0;
    prim_index = '0; prim_count = '0;
    min_x = '0; min_y = '0; min_z = '0; max_x = '0; max_y = '0; max_z = '0;
    for (int s = 0; s < 2; s++) begin m_base[s] = '0; m_idx[s] = '0; m_err[s] = '0; end

    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Single leaf at 0x1000.
    d = good_desc(1'b1);
    d.pidx = 19'd5; d.pcnt = 12'd3;
    d.min_x = 16'd1; d.min_y = 16'd1; d.min_z = 16'd1;
    d.max_x = 16'd2; d.max_y = 16'd2; d.max_z = 16'd2;
    issue(0, 1'b1, 32'h1000, d);
    drain();
    check("leaf_node_count", node_count64, 1);
    check("leaf_err", err64, 0);

    // Three interiors back to back: one acceptance every two cycles.
    acc_cycle.delete();
    issue(0, 1'b1, 32'h1000, good_desc(1'b0));
    issue(0, 1'b0, 32'h1000, good_desc(1'b0));
    issue(0, 1'b0, 32'h1000, good_desc(1'b0));
    drain();
    check("b2b_spacing_01", 128'(acc_cycle[1] - acc_cycle[0]), 2);
    check("b2b_spacing_12", 128'(acc_cycle[2] - acc_cycle[1]), 2);
    check("b2b_node_count", node_count64, 3);
    check("b2b_err", err64, 0);

    // Random descriptors under random back-pressure.
    rand_ready = 1'b1;
    issue(0, 1'b1, $urandom, rand_desc());
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(0, 1'b0, 32'h0, rand_desc());
    end
    drain();
    rand_ready = 1'b0;
    mem_ready  = 1'b1;
    check("rand_node_count", node_count64, m_idx[0]);
    check("rand_err", err64, m_err[0]);

    // Faulty nodes: flags accumulate, nodes still written.
    d = good_desc(1'b1); d.pcnt = 12'd0;
    issue(0, 1'b1, 32'h4000, d);
    d = good_desc(1'b0); d.axis = 2'd3;
    issue(0, 1'b0, 32'h0, d);
    d = good_desc(1'b0); d.axis = 2'd1; d.min_x = 16'd9; d.max_x = 16'd4;
    issue(0, 1'b0, 32'h0, d);
    drain();
    check("err_sticky", err64, 3'b011);
    check("err_nodes_written", node_count64, 3);

    // Start while busy, then reset during the next node's first beat.
    issue(0, 1'b1, 32'h2000, good_desc(1'b1));
    start = 1'b1;
    m_err[0][2] = 1'b1;
    @(negedge clk);
    start = 1'b0;
    issue(0, 1'b0, 32'h0, good_desc(1'b0));
    check("start_busy_err", err64, m_err[0]);
    check("start_busy_err2", err64[2], 1);
    check("beat0_before_reset", mem_valid64, 1);
    rst_n = 1'b0;
    exp64.delete();
    exp32.delete();
    for (int s = 0; s < 2; s++) begin m_base[s] = '0; m_idx[s] = '0; m_err[s] = '0; end
    repeat (2) @(negedge clk);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_beats_after_reset", mem_valid64, 0);
    end
    check_reset_outputs("post_reset");

    // 32-bit bus build: four beats per node, 4-byte address step.
    rand_ready = 1'b1;
    issue(1, 1'b1, 32'h3000, good_desc(1'b1));
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1, 1'b0, 32'h0, rand_desc());
    end
    drain();
    rand_ready = 1'b0;
    mem_ready  = 1'b1;
    check("bus32_node_count", node_count32, m_idx[1]);
    check("bus32_err", err32, m_err[1]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
